// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: valid/ready word load, per-frame bit order,
// shift-enable stall and registered frame status, with gap-free back-to-back frames.
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lsb_q, lsb_d;
    logic             so_d, sv_d, fs_d, done_d;
    logic             last, consume, accept;

    assign busy       = (state_q == SHIFT);
    assign last       = (cnt_q == CW'(1));
    assign consume    = busy && shift_en;
    // Ready also while the last bit is being consumed, so the next word follows with no gap.
    assign load_ready = !busy || (last && shift_en);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        lsb_d   = lsb_q;
        so_d    = serial_out;
        sv_d    = serial_valid;
        done_d  = consume && last;

        if (accept) begin
            state_d = SHIFT;
            cnt_d   = CW'(WIDTH);
            lsb_d   = lsb_first;
            sv_d    = 1'b1;
            if (lsb_first) begin
                so_d    = load_data[0];
                shreg_d = load_data >> 1;
            end else begin
                so_d    = load_data[WIDTH-1];
                shreg_d = load_data << 1;
            end
        end else if (consume) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
                sv_d    = 1'b0;
                so_d    = IDLE_LEVEL;
            end else begin
                cnt_d = cnt_q - CW'(1);
                if (lsb_q) begin
                    so_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end else begin
                    so_d    = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                end
            end
        end

        // Registered copy of busy && cnt==WIDTH, so it also holds through a first-bit stall.
        fs_d = (state_d == SHIFT) && (cnt_d == CW'(WIDTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            lsb_q        <= 1'b0;
            serial_out   <= IDLE_LEVEL;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            lsb_q        <= lsb_d;
            serial_out   <= so_d;
            serial_valid <= sv_d;
            frame_start  <= fs_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed checks on an 8-bit serializer plus a random-word sweep on 2- and 17-bit
// instances whose serial streams are reassembled and compared word by word.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance for directed steps
    logic       lv = 1'b0, lsb = 1'b0, sen = 1'b0;
    logic [7:0] ld = '0;
    logic       lr, so, sv, fs, bsy, dn;

    piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(lr), .load_data(ld),
        .lsb_first(lsb), .shift_en(sen), .serial_out(so), .serial_valid(sv),
        .frame_start(fs), .busy(bsy), .done(dn)
    );

    // sweep instances: index 0 is WIDTH=2, index 1 is WIDTH=17
    logic [1:0]       lvs = '0, lsbs = '0, sens = '0, acc = '0;
    logic [1:0][63:0] lds = '0;
    logic [1:0]       lrs, sos, svs, fss, bsys, dns;

    piso_serializer #(.WIDTH(2), .IDLE_LEVEL(1'b0)) dut_w2 (
        .clk(clk), .rst(rst), .load_valid(lvs[0]), .load_ready(lrs[0]), .load_data(lds[0][1:0]),
        .lsb_first(lsbs[0]), .shift_en(sens[0]), .serial_out(sos[0]), .serial_valid(svs[0]),
        .frame_start(fss[0]), .busy(bsys[0]), .done(dns[0])
    );

    piso_serializer #(.WIDTH(17), .IDLE_LEVEL(1'b0)) dut_w17 (
        .clk(clk), .rst(rst), .load_valid(lvs[1]), .load_ready(lrs[1]), .load_data(lds[1][16:0]),
        .lsb_first(lsbs[1]), .shift_en(sens[1]), .serial_out(sos[1]), .serial_valid(svs[1]),
        .frame_start(fss[1]), .busy(bsys[1]), .done(dns[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream reassembly: bit k of raw is the k-th bit consumed in the frame.
    logic [64:0] expq0[$], expq1[$];
    logic [63:0] gotq0[$], gotq1[$];
    logic [63:0] raw[2] = '{64'd0, 64'd0};
    int          nb[2] = '{0, 0};
    int          ndone[2] = '{0, 0};
    int          WS[2] = '{2, 17};

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                if (dns[s]) ndone[s]++;
                if (bsys[s] && sens[s]) begin
                    raw[s][nb[s]] = sos[s];
                    nb[s]++;
                    if (nb[s] == WS[s]) begin
                        if (s == 0) gotq0.push_back(raw[s]);
                        else        gotq1.push_back(raw[s]);
                        nb[s]  = 0;
                        raw[s] = '0;
                    end
                end
            end
        end
    end

    logic [7:0]  seq8;
    logic [10:0] seq11;
    logic [64:0] e;
    logic [63:0] g, rawe;
    int          w, nexp, ngot;

    initial begin
        sen = 1'b1;
        #2;
        chk("reset serial_out", so, 0);
        chk("reset serial_valid", sv, 0);
        chk("reset busy", bsy, 0);
        chk("reset done", dn, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("ready after reset", lr, 1);

        // MSB-first 0x1E
        @(negedge clk);
        lv = 1'b1; ld = 8'h1E; lsb = 1'b0; sen = 1'b1;
        seq8 = 8'b00011110;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("msb bit %0d", i), so, seq8[8-i]);
            chk($sformatf("msb frame_start %0d", i), fs, (i == 1));
            chk($sformatf("msb valid %0d", i), sv, 1);
            chk($sformatf("msb done %0d", i), dn, 0);
            lv = 1'b0;
        end
        @(negedge clk);
        chk("msb done pulse", dn, 1);
        chk("msb valid end", sv, 0);
        chk("msb idle level", so, 0);
        chk("msb busy end", bsy, 0);
        @(negedge clk);
        chk("msb done single", dn, 0);

        // LSB-first 0x1E with order and data disturbed mid-frame
        lv = 1'b1; ld = 8'h1E; lsb = 1'b1;
        seq8 = 8'b01111000;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("lsb bit %0d", i), so, seq8[8-i]);
            lv = 1'b0; lsb = ~lsb; ld = ~ld;
        end
        @(negedge clk);
        chk("lsb done pulse", dn, 1);
        lsb = 1'b0;

        // back-to-back 0xFF then 0x00
        @(negedge clk);
        lv = 1'b1; ld = 8'hFF;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk($sformatf("b2b bit %0d", i), so, (i <= 8));
            chk($sformatf("b2b valid %0d", i), sv, 1);
            chk($sformatf("b2b ready %0d", i), lr, (i == 8 || i == 16));
            chk($sformatf("b2b done %0d", i), dn, (i == 9));
            chk($sformatf("b2b frame_start %0d", i), fs, (i == 1 || i == 9));
            if (i == 1) ld = 8'h00;
            if (i == 9) lv = 1'b0;
        end
        @(negedge clk);
        chk("b2b done end", dn, 1);
        chk("b2b valid end", sv, 0);
        chk("b2b ready idle", lr, 1);

        // stall: shift_en low for three edges after bit 2
        @(negedge clk);
        lv = 1'b1; ld = 8'h1E; lsb = 1'b0;
        seq11 = 11'b00000011110;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            chk($sformatf("stall bit %0d", i), so, seq11[11-i]);
            chk($sformatf("stall valid %0d", i), sv, 1);
            chk($sformatf("stall done %0d", i), dn, 0);
            chk($sformatf("stall frame_start %0d", i), fs, (i == 1));
            if (i == 1) lv = 1'b0;
            if (i == 2) sen = 1'b0;
            if (i == 3) begin
                lv = 1'b1; ld = 8'hFF;
                #1 chk("stall ready", lr, 0);
            end
            if (i == 4) lv = 1'b0;
            if (i == 5) sen = 1'b1;
        end
        @(negedge clk);
        chk("stall done pulse", dn, 1);
        chk("stall valid end", sv, 0);
        @(negedge clk);
        chk("stall done single", dn, 0);
        chk("stall busy end", bsy, 0);

        // asynchronous reset mid-frame
        lv = 1'b1; ld = 8'hFF; lsb = 1'b0; sen = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort busy before", bsy, 1);
        rst = 1'b0;
        #1;
        chk("abort serial_out", so, 0);
        chk("abort serial_valid", sv, 0);
        chk("abort busy", bsy, 0);
        chk("abort done", dn, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("abort no done %0d", i), dn, 0);
            chk($sformatf("abort ready %0d", i), lr, 1);
        end

        // random sweep on WIDTH=2 and WIDTH=17
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (!lvs[s] || acc[s]) begin
                    lvs[s]  = ($urandom_range(0, 3) != 0);
                    lds[s]  = {$urandom, $urandom};
                    lsbs[s] = 1'($urandom_range(0, 1));
                end
                sens[s] = ($urandom_range(0, 4) != 0);
            end
            #1;
            for (int s = 0; s < 2; s++) begin
                acc[s] = lvs[s] && lrs[s];
                if (acc[s]) begin
                    if (s == 0) expq0.push_back({lsbs[0], 62'd0, lds[0][1:0]});
                    else        expq1.push_back({lsbs[1], 47'd0, lds[1][16:0]});
                end
            end
        end
        @(negedge clk);
        lvs = '0; sens = 2'b11;
        repeat (40) @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            w    = WS[s];
            nexp = (s == 0) ? expq0.size() : expq1.size();
            ngot = (s == 0) ? gotq0.size() : gotq1.size();
            chk($sformatf("w%0d frame count", w), ngot, nexp);
            chk($sformatf("w%0d done count", w), ndone[s], nexp);
            for (int f = 0; f < nexp && f < ngot; f++) begin
                e    = (s == 0) ? expq0[f] : expq1[f];
                g    = (s == 0) ? gotq0[f] : gotq1[f];
                rawe = '0;
                for (int k = 0; k < w; k++)
                    rawe[k] = e[64] ? e[k] : e[w-1-k];
                chk($sformatf("w%0d word %0d", w, f), g, rawe);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
